// File: rtl/pe_ctrl_pkg.sv
// Shared PE-control definitions: arbiter FSM states, default widths, output buffer depth.
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_BURST = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 6;
  localparam int OBUF_DEPTH = 2;

  // Index width for an n-way select, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  // Scan NUM_REQ positions starting at the pointer; the first hit wins.
  always_comb begin : pick
    int  j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/glb_rd_arbiter.sv
// GLB read-port arbiter: round-robin burst grants, credit-gated GLB reads into a
// 2-entry output buffer, valid/ready stream toward the granted PE.
// Optional macro GLB_ARB_PRIO_EN: requester 0 gets strict priority, rr pointer untouched when it wins.
module glb_rd_arbiter
  import pe_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      glb_ren,
  output logic [ADDR_W-1:0]         glb_raddr,
  input  logic [DATA_W-1:0]         glb_rdata,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [NUM_REQ-1:0]        out_dst,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int PTR_W = idx_w(OBUF_DEPTH);
  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q;
  logic [NUM_REQ-1:0]  arb_gnt, sel_gnt, dst_q;
  logic [IDX_W-1:0]    arb_idx, sel_idx;
  logic                arb_vld, upd_ptr;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    beats_q;
  logic                infl_q, infl_last_q;
  logic [DATA_W-1:0]   buf_data_q [OBUF_DEPTH];
  logic [OBUF_DEPTH-1:0] buf_last_q;
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                push, pop, credit_ok, ren;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  // Winner selection; optional strict priority for requester 0 bypasses the rr pointer.
  always_comb begin
    sel_gnt = arb_gnt;
    sel_idx = arb_idx;
    upd_ptr = 1'b1;
`ifdef GLB_ARB_PRIO_EN
    if (req[0]) begin
      sel_gnt    = '0;
      sel_gnt[0] = 1'b1;
      sel_idx    = '0;
      upd_ptr    = 1'b0;
    end
`endif
  end

  assign push = infl_q;
  assign pop  = out_valid && out_ready;
  // A word leaving this cycle frees its slot before the new read's data can land,
  // which keeps a full 1 word/cycle stream with only two entries.
  assign credit_ok = (int'(cnt_q) + int'(infl_q)) < (OBUF_DEPTH + int'(pop));

  // Next state and FSM outputs.
  always_comb begin
    state_d = state_q;
    gnt     = '0;
    ren     = 1'b0;
    case (state_q)
      ST_IDLE:  if (|req) state_d = ST_ARB;
      ST_ARB: begin
        if (arb_vld) begin
          gnt     = sel_gnt;
          state_d = ST_BURST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        ren = credit_ok;
        if (credit_ok && beats_q == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (pop && out_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM, arbitration and read-issue state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      dst_q       <= '0;
      addr_q      <= '0;
      beats_q     <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      infl_q      <= ren;
      infl_last_q <= ren && (beats_q == '0);
      if (state_q == ST_ARB && arb_vld) begin
        dst_q   <= sel_gnt;
        addr_q  <= req_addr[sel_idx*ADDR_W +: ADDR_W];
        beats_q <= req_len[sel_idx*LEN_W +: LEN_W];
        if (upd_ptr) ptr_q <= (sel_idx == IDX_W'(NUM_REQ-1)) ? '0 : sel_idx + IDX_W'(1);
      end else if (ren) begin
        addr_q  <= addr_q + ADDR_W'(1);
        beats_q <= beats_q - LEN_W'(1);
      end
    end
  end

  // Output buffer control: pointers, occupancy and last flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      buf_last_q <= '0;
    end else begin
      if (push) begin
        buf_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Buffer payload; only read while its slot is occupied, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) buf_data_q[wr_ptr_q] <= glb_rdata;
  end

  assign glb_ren   = ren;
  assign glb_raddr = addr_q;
  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? buf_data_q[rd_ptr_q] : '0;
  assign out_last  = out_valid && buf_last_q[rd_ptr_q];
  assign out_dst   = (state_q == ST_BURST || state_q == ST_DRAIN) ? dst_q : '0;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_glb_rd_arbiter.sv
// Directed bench for glb_rd_arbiter: reset, single burst, rr order, backpressure,
// address wrap, max length, mid-burst reset, priority/rr selection.
module tb_glb_rd_arbiter;
  localparam int N = 4, AW = 10, DW = 16, LW = 6;

  logic            clk = 1'b0, rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N-1:0]    gnt, out_dst;
  logic            glb_ren, out_valid, out_last, busy;
  logic            out_ready = 1'b1;
  logic [AW-1:0]   glb_raddr;
  logic [DW-1:0]   glb_rdata = '0, out_data;

  glb_rd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len),
    .gnt(gnt), .glb_ren(glb_ren), .glb_raddr(glb_raddr), .glb_rdata(glb_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_dst(out_dst),
    .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return 16'hA000 ^ {6'b0, a};
  endfunction

  // GLB model: one-cycle read latency
  always @(posedge clk) if (glb_ren) glb_rdata <= mem_f(glb_raddr);

  // Stream monitor
  int ren_cnt, acc_cnt, max_out, stab_err;
  logic [DW-1:0] q_data[$];
  logic          q_last[$];
  logic [N-1:0]  q_dst[$];
  int            q_cyc[$];
  logic [AW-1:0] ren_addr[$];
  logic          pv = 1'b0, pr = 1'b0;
  logic [DW-1:0] pd = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (pv && !pr && (!out_valid || out_data !== pd)) stab_err++;
      if (ren_cnt - acc_cnt > max_out) max_out = ren_cnt - acc_cnt;
      if (glb_ren) begin ren_cnt++; ren_addr.push_back(glb_raddr); end
      if (out_valid && out_ready) begin
        acc_cnt++;
        q_data.push_back(out_data); q_last.push_back(out_last);
        q_dst.push_back(out_dst);   q_cyc.push_back(cyc);
      end
      pv = out_valid; pr = out_ready; pd = out_data;
    end else pv = 1'b0;
  end

  task automatic clear_mon();
    ren_cnt = 0; acc_cnt = 0; max_out = 0; stab_err = 0;
    q_data.delete(); q_last.delete(); q_dst.delete(); q_cyc.delete(); ren_addr.delete();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW]  = l;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 rst = 1'b1; req = '0; out_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_gnt(output logic [N-1:0] g, output int c);
    g = '0; c = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt != '0) begin g = gnt; c = cyc; return; end
    end
  endtask

  task automatic wait_idle(output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin c = cyc; return; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; #1;
    n_cmp++; if ({gnt, glb_ren, glb_raddr, out_data, out_dst, out_last} !== '0) begin
      n_err++; $display("FAIL reset_outs: got %h want 0", {gnt, glb_ren, glb_raddr, out_data, out_dst, out_last}); end
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_vld_busy: got %b%b want 00", out_valid, busy); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single();
    logic [N-1:0] g; int cg, ci;
    clear_mon(); set_req(1, 10'h010, 6'd3); req = 4'b0010;
    wait_gnt(g, cg);
    @(posedge clk); #1 req = '0;
    wait_idle(ci);
    n_cmp++; if (g !== 4'b0010) begin n_err++; $display("FAIL single_gnt: got %b want 0010", g); end
    n_cmp++; if (q_data.size() != 4) begin n_err++; $display("FAIL single_cnt: got %0d want 4", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 4; i++) begin
      n_cmp++; if (q_data[i] !== mem_f(10'h010 + 10'(i)) || q_last[i] !== (i == 3) || q_dst[i] !== 4'b0010) begin
        n_err++; $display("FAIL single_beat%0d: got %h/%b/%b want %h/%b/0010", i, q_data[i], q_last[i], q_dst[i], mem_f(10'h010 + 10'(i)), i == 3); end
      n_cmp++; if (q_cyc[i] != cg + 3 + i) begin
        n_err++; $display("FAIL single_timing%0d: got %0d want %0d", i, q_cyc[i] - cg, 3 + i); end
    end
    n_cmp++; if (ci != cg + 7) begin n_err++; $display("FAIL single_busy_drop: got %0d want %0d", ci - cg, 7); end
  endtask

  task automatic test_all_req();
    logic [N-1:0] g; int c, ci;
    logic [N-1:0] exp_g;
    apply_reset(); clear_mon();
    for (int i = 0; i < N; i++) set_req(i, 10'h100 + 10'(i * 16), 6'd0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g, c);
      exp_g = 4'b0001 << (k % 4);
      n_cmp++; if (g !== exp_g) begin n_err++; $display("FAIL rr_gnt%0d: got %b want %b", k, g, exp_g); end
    end
    @(posedge clk); #1 req = '0;
    wait_idle(ci);
    n_cmp++; if (q_data.size() != 5) begin n_err++; $display("FAIL rr_cnt: got %0d want 5", q_data.size()); end
    for (int k = 0; k < q_data.size() && k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      n_cmp++; if (q_dst[k] !== exp_g || q_last[k] !== 1'b1 || q_data[k] !== mem_f(10'h100 + 10'((k % 4) * 16))) begin
        n_err++; $display("FAIL rr_beat%0d: got %b/%b/%h want %b/1/%h", k, q_dst[k], q_last[k], q_data[k], exp_g, mem_f(10'h100 + 10'((k % 4) * 16))); end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] g; int c; bit done;
    clear_mon(); set_req(2, 10'h040, 6'd7); req = 4'b0100;
    wait_gnt(g, c);
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1 req = '0; out_ready = ~out_ready;
      @(negedge clk); if (!busy) done = 1'b1;
    end
    #1 out_ready = 1'b1;
    n_cmp++; if (!done) begin n_err++; $display("FAIL bp_timeout: got busy want idle"); end
    n_cmp++; if (q_data.size() != 8 || ren_cnt != 8) begin
      n_err++; $display("FAIL bp_counts: got %0d words %0d reads want 8/8", q_data.size(), ren_cnt); end
    for (int i = 0; i < q_data.size() && i < 8; i++) begin
      n_cmp++; if (q_data[i] !== mem_f(10'h040 + 10'(i)) || q_last[i] !== (i == 7)) begin
        n_err++; $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, q_data[i], q_last[i], mem_f(10'h040 + 10'(i)), i == 7); end
    end
    n_cmp++; if (max_out > 2) begin n_err++; $display("FAIL bp_outstanding: got %0d want <=2", max_out); end
    n_cmp++; if (stab_err != 0) begin n_err++; $display("FAIL bp_stable: got %0d changes want 0", stab_err); end
  endtask

  task automatic test_wrap();
    logic [N-1:0] g; int c, ci;
    logic [AW-1:0] ea [4];
    ea[0] = 10'h3FE; ea[1] = 10'h3FF; ea[2] = 10'h000; ea[3] = 10'h001;
    clear_mon(); set_req(3, 10'h3FE, 6'd3); req = 4'b1000;
    wait_gnt(g, c);
    @(posedge clk); #1 req = '0;
    wait_idle(ci);
    n_cmp++; if (ren_addr.size() != 4 || q_data.size() != 4) begin
      n_err++; $display("FAIL wrap_cnt: got %0d/%0d want 4/4", ren_addr.size(), q_data.size()); end
    for (int i = 0; i < ren_addr.size() && i < q_data.size() && i < 4; i++) begin
      n_cmp++; if (ren_addr[i] !== ea[i] || q_data[i] !== mem_f(ea[i])) begin
        n_err++; $display("FAIL wrap_addr%0d: got %h/%h want %h/%h", i, ren_addr[i], q_data[i], ea[i], mem_f(ea[i])); end
    end
  endtask

  task automatic test_max_len();
    logic [N-1:0] g; int c, ci, nl;
    clear_mon(); set_req(0, 10'h200, 6'h3F); req = 4'b0001;
    wait_gnt(g, c);
    @(posedge clk); #1 req = '0;
    wait_idle(ci);
    nl = 0;
    foreach (q_last[i]) if (q_last[i]) nl++;
    n_cmp++; if (q_data.size() != 64 || nl != 1) begin
      n_err++; $display("FAIL maxlen_cnt: got %0d words %0d lasts want 64/1", q_data.size(), nl); end
    n_cmp++; if (q_data.size() == 64 && (q_data[63] !== mem_f(10'h23F) || q_last[63] !== 1'b1)) begin
      n_err++; $display("FAIL maxlen_final: got %h/%b want %h/1", q_data[63], q_last[63], mem_f(10'h23F)); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] g; int c, ci, n;
    clear_mon(); set_req(2, 10'h080, 6'd7); req = 4'b0100;
    wait_gnt(g, c);
    @(posedge clk); #1 req = '0;
    n = 0;
    for (int i = 0; i < 50 && n < 3; i++) begin
      @(negedge clk); if (out_valid && out_ready) n++;
    end
    #2 rst = 1'b1; #1;
    n_cmp++; if ({gnt, glb_ren, glb_raddr, out_valid, out_data, out_dst, out_last, busy} !== '0) begin
      n_err++; $display("FAIL midrst_outs: got %h want 0", {gnt, glb_ren, glb_raddr, out_valid, out_data, out_dst, out_last, busy}); end
    @(posedge clk); #1 rst = 1'b0;
    clear_mon(); set_req(1, 10'h0C0, 6'd1); set_req(3, 10'h0E0, 6'd1); req = 4'b1010;
    wait_gnt(g, c);
    @(posedge clk); #1 req = '0;
    wait_idle(ci);
    n_cmp++; if (g !== 4'b0010) begin n_err++; $display("FAIL midrst_ptr: got %b want 0010", g); end
    n_cmp++; if (q_data.size() != 2 || q_data[0] !== mem_f(10'h0C0) || q_data[1] !== mem_f(10'h0C1)) begin
      n_err++; $display("FAIL midrst_data: got %0d words first %h want 2 words %h", q_data.size(), (q_data.size() > 0) ? q_data[0] : 16'h0, mem_f(10'h0C0)); end
  endtask

  task automatic test_priority();
    logic [N-1:0] g, e1, e2; int c, ci;
`ifdef GLB_ARB_PRIO_EN
    e1 = 4'b0001; e2 = 4'b0100;
`else
    e1 = 4'b0100; e2 = 4'b1000;
`endif
    apply_reset(); clear_mon();
    for (int i = 0; i < N; i++) set_req(i, 10'h300 + 10'(i * 16), 6'd0);
    req = 4'b0010;
    wait_gnt(g, c);
    @(posedge clk); #1 req = '0;
    wait_idle(ci);
    req = 4'b1111;
    wait_gnt(g, c);
    n_cmp++; if (g !== e1) begin n_err++; $display("FAIL prio_first: got %b want %b", g, e1); end
    @(posedge clk); #1 req = 4'b1110;
    wait_gnt(g, c);
    n_cmp++; if (g !== e2) begin n_err++; $display("FAIL prio_second: got %b want %b", g, e2); end
    @(posedge clk); #1 req = '0;
    wait_idle(ci);
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_backpressure();
    test_wrap();
    test_max_len();
    test_reset_mid();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
